// File: rtl/fifo_uart_pkg.sv
//------------------------------------------------------------------------------
// fifo_uart_pkg : shared types and defaults for the FIFO-draining UART TX
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_uart_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_baud.sv
//------------------------------------------------------------------------------
// uart_baud_gen : bit-period counter, bit_tick in the last cycle of each period
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    bit_tick = (cnt_q == c_last);
    if (clear || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
//------------------------------------------------------------------------------
// fifo_uart_tx : pops bytes from sync_fifo and sends 8N1 (or 8E1) serial frames
// Optional even parity bit: define UART_TX_PARITY_EN.   Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int            IW         = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] c_last_bit = IW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              baud_clear;
  logic              bit_tick;
  logic              pop;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  // The only source of the pop strobe; it cannot fire while empty or in reset.
  assign pop        = !reset && (state_q == IDLE) && tx_en && !fifo_empty;
  assign fifo_rd_en = pop;
  assign tx         = tx_q;
  assign busy       = pop || (state_q != IDLE);
  assign frame_done = (state_q == STOP) && bit_tick;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = tx_q;
    baud_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) state_d = LOAD;
      end
      LOAD: begin
        shift_d    = fifo_data;
`ifdef UART_TX_PARITY_EN
        parity_d   = ^fifo_data;
`endif
        tx_d       = 1'b0;
        baud_clear = 1'b1;
        state_d    = START;
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == c_last_bit) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity_q;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
//------------------------------------------------------------------------------
// tb_fifo_uart_tx : self-checking bench, queue-based FIFO model + frame model
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic       hold_ne = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en, tx, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int pushes   = 0;
  int pops     = 0;
  int bad_pops = 0;
  logic [7:0] fq[$];
  vec_t tbl[6];
  logic [7:0] rnd[6];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // sync_fifo read side: data_out registered on the pop edge.
  assign fifo_empty = hold_ne ? 1'b0 : (pushes == pops);

  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      if (fq.size() == 0) bad_pops <= bad_pops + 1;
      else                fifo_data <= fq.pop_front();
      pops <= pops + 1;
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b01, b, 1'b0};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    pushes++;
  endtask

  task automatic wait_pop(input string name, input int exp_cycles);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (fifo_rd_en === 1'b1) seen = 1;
    end
    chk({name, "_pop_latency"}, seen ? n : -1, exp_cycles);
    if (seen) chk({name, "_pop_cycle_tx"}, {31'd0, tx}, 1);
  endtask

  // Entered in the pop cycle; returns in the last cycle of the stop bit.
  task automatic run_frame(input string name, input logic [10:0] fr, input int drop_at);
    int done_cnt = 0;
    int bad;
    @(negedge clk);
    chk({name, "_load_tx_busy"}, {30'd0, tx, busy}, 32'd3);
    for (int b = 0; b < NB; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (b * CPB + c == drop_at) tx_en = 1'b0;
        if (tx !== fr[b] || busy !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
        if (frame_done === 1'b1) begin
          done_cnt++;
          if (!(b == NB - 1 && c == CPB - 1)) bad++;
        end
      end
      chk($sformatf("%s_bit%0d_bad_cycles", name, b), bad, 0);
    end
    chk({name, "_frame_done_count"}, done_cnt, 1);
  endtask

  initial begin
    int cnt_a, cnt_b, p0, done_cnt;

`ifdef UART_TX_PARITY_EN
    tbl[0] = '{8'hA5, 11'b1_0_1010_0101_0};
    tbl[1] = '{8'h00, 11'b1_0_0000_0000_0};
    tbl[2] = '{8'hFF, 11'b1_0_1111_1111_0};
    tbl[3] = '{8'h55, 11'b1_0_0101_0101_0};
    tbl[4] = '{8'h3C, 11'b1_0_0011_1100_0};
    tbl[5] = '{8'h07, 11'b1_1_0000_0111_0};
`else
    tbl[0] = '{8'hA5, 11'b0_1_1010_0101_0};
    tbl[1] = '{8'h00, 11'b0_1_0000_0000_0};
    tbl[2] = '{8'hFF, 11'b0_1_1111_1111_0};
    tbl[3] = '{8'h55, 11'b0_1_0101_0101_0};
    tbl[4] = '{8'h3C, 11'b0_1_0011_1100_0};
    tbl[5] = '{8'h07, 11'b0_1_0000_0111_0};
`endif

    // Reset held two cycles with a non-empty FIFO
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_outputs", {28'd0, tx, fifo_rd_en, busy, frame_done}, 32'h8);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {28'd0, tx, fifo_rd_en, busy, frame_done}, 32'h8);
    hold_ne = 1'b0;
    tx_en   = 1'b1;

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      align();
      push(tbl[i].data);
      wait_pop($sformatf("tbl%0d", i), 1);
      run_frame($sformatf("tbl%0d", i), tbl[i].frame, -1);
    end

    // Empty FIFO: nothing may be popped, line stays idle
    align();
    cnt_a = 0; cnt_b = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0) cnt_a++;
      if (tx !== 1'b1) cnt_b++;
    end
    chk("empty_rd_en_cycles", cnt_a, 0);
    chk("empty_tx_low_cycles", cnt_b, 0);

    // Back-to-back frames with the 2-cycle idle gap
    align();
    p0 = pops;
    push(8'h00); push(8'hFF); push(8'h55);
    wait_pop("b2b0", 1); run_frame("b2b0", frame_of(8'h00), -1);
    wait_pop("b2b1", 1); run_frame("b2b1", frame_of(8'hFF), -1);
    wait_pop("b2b2", 1); run_frame("b2b2", frame_of(8'h55), -1);
    @(negedge clk);
    chk("b2b_pop_count", pops - p0, 3);
    chk("b2b_fifo_empty", {31'd0, fifo_empty}, 1);

    // tx_en dropped mid-frame
    align();
    push(8'h3C); push(8'h81);
    wait_pop("txen", 1);
    run_frame("txen", frame_of(8'h3C), 5 * CPB + 1);
    cnt_a = 0; cnt_b = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0) cnt_a++;
      if (tx !== 1'b1) cnt_b++;
    end
    chk("txen_off_rd_en_cycles", cnt_a, 0);
    chk("txen_off_tx_low_cycles", cnt_b, 0);
    align();
    tx_en = 1'b1;
    wait_pop("resume", 1);
    run_frame("resume", frame_of(8'h81), -1);

    // Reset during data bit 3; the popped byte is dropped
    align();
    push(8'h96); push(8'h4B);
    wait_pop("rstmid", 1);
    @(negedge clk);
    done_cnt = 0;
    repeat (4 * CPB + 1) begin
      @(negedge clk);
      if (frame_done === 1'b1) done_cnt++;
    end
    chk("rstmid_bit3_tx", {31'd0, tx}, 0);
    reset = 1'b1;
    @(negedge clk);
    if (frame_done === 1'b1) done_cnt++;
    chk("rstmid_outputs", {28'd0, tx, fifo_rd_en, busy, frame_done}, 32'h8);
    chk("rstmid_no_frame_done", done_cnt, 0);
    align();
    reset = 1'b0;
    wait_pop("after_rst", 1);
    run_frame("after_rst", frame_of(8'h4B), -1);

    // Randomized bytes against the frame model
    align();
    for (int k = 0; k < 6; k++) begin
      rnd[k] = 8'($urandom_range(0, 255));
      push(rnd[k]);
    end
    for (int k = 0; k < 6; k++) begin
      wait_pop($sformatf("rnd%0d", k), 1);
      run_frame($sformatf("rnd%0d_%02h", k, rnd[k]), frame_of(rnd[k]), -1);
    end

    @(negedge clk);
    chk("no_pop_when_empty", bad_pops, 0);
    chk("total_pops", pops, pushes);
    chk("final_fifo_empty", {31'd0, fifo_empty}, 1);
    chk("final_tx_idle", {31'd0, tx}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
